stopwatch_core: RTL
===================

# stopwatch_core

Stopwatch timekeeping and control stage fed by the button debouncer. Consumes single-cycle debounced rising-edge pulses from three buttons (start/stop, lap, clear) and runs a four-state control FSM. Maintains a BCD mm:ss.cc time count with a divided-down tick. Presents either the live count or a frozen lap snapshot to the display driver downstream.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `TICK_HZ`, 100, count rate in Hz (one centisecond per tick). `CLK_HZ` must be an integer multiple of `TICK_HZ`. `DIV = CLK_HZ/TICK_HZ` must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_rise`  in  1  one-cycle pulse, start/stop button pressed.
- `lap_rise`  in  1  one-cycle pulse, lap button pressed.
- `clear_rise`  in  1  one-cycle pulse, clear button pressed.
- `time_bcd`  out  24  displayed time, six BCD digits `{m10,m1,s10,s1,c10,c1}`, MSB first.
- `running`  out  1  high in RUN and LAP.
- `lap_active`  out  1  high in LAP (display frozen).
- `tick`  out  1  one-cycle pulse on every count increment.
- `wrap`  out  1  one-cycle pulse when the count rolls 59:59.99 → 00:00.00.

## Operation
- Registers:
  - FSM state: IDLE, RUN, PAUSE, LAP.
  - Prescaler `pre`, width `$clog2(DIV)`.
  - Live count `cnt`, 24-bit BCD.
  - Lap latch `lap`, 24-bit BCD.
- Reset (async assert, sync release) sets:
  - state to IDLE;
  - `pre`, `cnt`, `lap` to 0;
  - all outputs to 0.
- Transitions:
  - IDLE: `start` → RUN; `lap`, `clear` ignored.
  - RUN: `start` → PAUSE; `lap` → LAP, with `lap <= cnt` captured on the same edge; `clear` ignored.
  - LAP: `lap` → RUN (display live again); `start` → PAUSE (display live); `clear` ignored.
  - PAUSE: `start` → RUN; `clear` → IDLE, and sets `cnt <= 0` and `pre <= 0`; `lap` ignored.
- Simultaneous pulses: only pulses valid in the current state are considered. Priority among them is clear > start > lap. Lower-priority pulses in the same cycle are dropped, not queued.
- Prescaler:
  - Increments in RUN and LAP, wrapping at `DIV-1`.
  - Holds its value in IDLE and PAUSE, so the fractional tick is preserved across pause/resume.
  - Cleared only by reset or clear.
- Count:
  - When running and `pre == DIV-1`, `cnt` increments by one centisecond and `tick` pulses.
  - Digit rollover limits: c1 9→0, c10 9→0, s1 9→0, s10 5→0, m1 9→0, m10 5→0, each with carry to the next digit.
  - At 59:59.99 the count goes to all-zero, `wrap` pulses with `tick`, and counting continues.
- Outputs:
  - `time_bcd` = `lap` in LAP, otherwise `cnt`.
  - `running` and `lap_active` are registered, decoded from the next state, so they change on the same edge as the state.

## Timing
- Pulse sampled in cycle N → state, `running`, `lap_active`, `time_bcd` source change at the edge ending cycle N (visible in N+1).
- Start from IDLE with `pre=0`: first `tick`/increment is visible exactly `DIV` cycles after `running` rises.
- Stop pulse in the same cycle as `pre == DIV-1`: that increment still occurs, because the state in that cycle is RUN. `pre` then holds at 0.
- Lap capture takes `cnt` as registered at the capturing edge, i.e. excluding any increment made on that same edge. `cnt` still increments.
- `tick` and `wrap` are single-cycle, registered, and coincide with the `cnt` update edge.
- `rst_n` asserted mid-run: all state clears immediately. No tick or wrap is emitted during or after reset until a new start.

## Test plan
- Reset/idle, `DIV=10`: release reset, pulse `lap`, then `clear` → `time_bcd=0`, `running=0`, no `tick` for 100 cycles.
- Basic count, `DIV=10`: `start` at cycle 0 → `running=1` at cycle 1; `tick` at cycles 10, 20, …; after 105 ticks `time_bcd=24'h000105` (00:01.05).
- Pause/resume/clear, `DIV=10`: run 47 cycles, `start`, wait 50, `start`, run 13 → exactly 5 ticks total, `time_bcd=24'h000005`. Then `start` (pause), `clear` → `time_bcd=0`, IDLE.
- Lap:
  - Running at 00:00.12: `lap` → `lap_active=1`, `time_bcd` frozen at `24'h000012` while `tick` continues.
  - Second `lap` at `cnt=24'h000030` → display shows `24'h000030` next cycle.
- Priority, `DIV=10`: in PAUSE, assert `clear_rise` and `start_rise` together → IDLE, `cnt=0`, `running=0`. In RUN, `start` and `lap` together → PAUSE, `lap` not captured.
- Wrap, `DIV=2`: run 360000 ticks → `time_bcd` passes `24'h595999` then `24'h000000`, with `wrap` high for exactly one cycle coincident with that `tick`. Also assert `rst_n` low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_core_if.sv
// Button-pulse / display bundle between the debouncer, the stopwatch core
// and the display driver.
//   start_rise, lap_rise, clear_rise : one-cycle debounced button pulses
//   time_bcd   : displayed time {m10,m1,s10,s1,c10,c1}, BCD, MSB first
//   running    : high while counting (RUN or LAP)
//   lap_active : high while the display is frozen on a lap snapshot
//   tick       : one-cycle pulse on every centisecond increment
//   wrap       : one-cycle pulse when 59:59.99 rolls to 00:00.00
// The master modport is the stimulus/observer side; the slave modport is
// the core.
interface stopwatch_core_if;
  logic        start_rise;
  logic        lap_rise;
  logic        clear_rise;
  logic [23:0] time_bcd;
  logic        running;
  logic        lap_active;
  logic        tick;
  logic        wrap;

  modport master (
    output start_rise, lap_rise, clear_rise,
    input  time_bcd, running, lap_active, tick, wrap
  );

  modport slave (
    input  start_rise, lap_rise, clear_rise,
    output time_bcd, running, lap_active, tick, wrap
  );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping and control.
// A four-state FSM (IDLE/RUN/PAUSE/LAP) driven by debounced button pulses
// controls a prescaler dividing clk down to TICK_HZ and a BCD mm:ss.cc
// counter. In LAP the display shows a snapshot of the count while the
// live count keeps running.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : stopwatch_core_if.slave (button pulses in, display out)
module stopwatch_core #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  // Per-digit rollover limits, same digit order as the count.
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre;
  logic [23:0]   cnt;
  logic [23:0]   lap;
  logic          running;
  logic          lap_active;
  logic          tick;
  logic          wrap;

  logic          running_nxt;
  logic          lap_active_nxt;
  logic          do_clear;
  logic          do_capture;
  logic          active;
  logic [23:0]   cnt_inc;
  logic          cnt_wrap;

  // Next state. Only pulses meaningful in the current state are looked at;
  // within a state clear beats start beats lap, and losers are dropped.
  always_comb begin
    state_nxt  = state;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_rise) state_nxt = RUN;
      end
      RUN: begin
        if (bus.start_rise) begin
          state_nxt = PAUSE;
        end else if (bus.lap_rise) begin
          state_nxt  = LAP;
          do_capture = 1'b1;
        end
      end
      LAP: begin
        if (bus.start_rise)    state_nxt = PAUSE;
        else if (bus.lap_rise) state_nxt = RUN;
      end
      PAUSE: begin
        if (bus.clear_rise) begin
          state_nxt = IDLE;
          do_clear  = 1'b1;
        end else if (bus.start_rise) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they move on the
  // same edge as the state itself.
  always_comb begin
    running_nxt    = (state_nxt == RUN) || (state_nxt == LAP);
    lap_active_nxt = (state_nxt == LAP);
  end

  // BCD increment with per-digit limits; carry out of the top digit means
  // the count rolled over from 59:59.99.
  always_comb begin
    logic carry;
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (cnt[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
          cnt_inc[i*4 +: 4] = '0;
        end else begin
          cnt_inc[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    cnt_wrap = carry;
  end

  // Counting follows the current state, so a stop pulse landing on the
  // terminal prescaler value still lets that increment happen.
  assign active = (state == RUN) || (state == LAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre        <= '0;
      cnt        <= '0;
      lap        <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      running    <= running_nxt;
      lap_active <= lap_active_nxt;
      tick       <= 1'b0;
      wrap       <= 1'b0;
      if (do_clear) begin
        pre <= '0;
        cnt <= '0;
      end else if (active) begin
        if (pre == PRE_MAX) begin
          pre  <= '0;
          cnt  <= cnt_inc;
          tick <= 1'b1;
          wrap <= cnt_wrap;
        end else begin
          pre <= pre + PW'(1);
        end
      end
      // Snapshot takes the pre-edge count, excluding a same-edge increment.
      if (do_capture) lap <= cnt;
    end
  end

  assign bus.time_bcd   = (state == LAP) ? lap : cnt;
  assign bus.running    = running;
  assign bus.lap_active = lap_active;
  assign bus.tick       = tick;
  assign bus.wrap       = wrap;

endmodule
